// File: rtl/toggle_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toggle_arb_pkg
// Purpose  : Shared types and constants for the toggle arbiter slice.
//            Holds the FSM state encoding, the default NREQ/LENW sizes and
//            a one-hot helper used to build the registered grant vector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package toggle_arb_pkg;

    localparam int c_DEF_NREQ = 4;
    localparam int c_DEF_LENW = 4;
    localparam int c_MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // One-hot vector with bit idx set, sized for the largest supported NREQ.
    // Callers truncate to their own requester count.
    function automatic logic [c_MAX_NREQ-1:0] onehot(input logic [2:0] idx);
        logic [c_MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : toggle_arb_rr_pick
// Purpose  : Combinational pick of the first set request bit at or after a
//            pointer, wrapping past the top back to index 0. With the pointer
//            tied to zero it degenerates to lowest-index-wins priority.
// Ports    : i_req   - request vector (NREQ bits)
//            i_ptr   - search start index
//            o_idx   - index of the selected requester
//            o_valid - high when any request bit is set
// Revision : 1.0 - initial release
// ============================================================================
module toggle_arb_rr_pick
    import toggle_arb_pkg::*;
#(
    parameter int NREQ = c_DEF_NREQ,
    parameter int PTRW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PTRW-1:0] i_ptr,
    output logic [PTRW-1:0] o_idx,
    output logic            o_valid
);

    always_comb begin
        int w_j;
        w_j     = 0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            // Wrap by subtraction so NREQ need not be a power of two.
            w_j = int'(i_ptr) + i;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!o_valid && i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = PTRW'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : toggle_arbiter
// Purpose  : Shares one T flip-flop (q) between NREQ requesters. A granted
//            requester receives a burst of len toggles, then a one-cycle done
//            pulse; the grant is then released and arbitration resumes.
//            Build option TOGGLE_ARB_FIXED_PRIO_EN selects fixed priority
//            (lowest index wins); default is round-robin.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-high reset
//            req   - per-requester request, held until its done
//            len   - packed burst lengths, requester i at [i*LENW +: LENW]
//            gnt   - registered one-hot grant
//            t_en  - toggle enable, high in BURST
//            q     - shared toggle state
//            busy  - high whenever not IDLE
//            done  - one-cycle pulse at the end of each grant
// Revision : 1.0 - initial release
// ============================================================================
module toggle_arbiter
    import toggle_arb_pkg::*;
#(
    parameter int NREQ = c_DEF_NREQ,
    parameter int LENW = c_DEF_LENW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    output logic [NREQ-1:0]      gnt,
    output logic                 t_en,
    output logic                 q,
    output logic                 busy,
    output logic                 done
);

    localparam int c_PTRW = $clog2(NREQ);

    arb_state_t        r_state;
    logic [LENW-1:0]   r_cnt;
    logic [c_PTRW-1:0] r_sel;
    logic [NREQ-1:0]   r_gnt;
    logic              r_q;

    logic [c_PTRW-1:0] w_ptr;
    logic [c_PTRW-1:0] w_idx;
    logic              w_valid;
    logic [LENW-1:0]   w_len;
    logic [NREQ-1:0]   w_oh;
    logic [c_PTRW-1:0] w_ptr_next;

`ifdef TOGGLE_ARB_FIXED_PRIO_EN
    // Search always starts at requester 0.
    assign w_ptr = '0;
`else
    logic [c_PTRW-1:0] r_ptr;
    assign w_ptr = r_ptr;
`endif

    toggle_arb_rr_pick #(
        .NREQ (NREQ),
        .PTRW (c_PTRW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (w_ptr),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_len      = len[w_idx*LENW +: LENW];
    assign w_oh       = NREQ'(onehot(3'(w_idx)));
    assign w_ptr_next = (r_sel == c_PTRW'(NREQ-1)) ? '0 : r_sel + 1'b1;

    // Status outputs are plain decodes of the state register.
    assign t_en = (r_state == BURST);
    assign done = (r_state == DONE);
    assign busy = (r_state != IDLE);
    assign gnt  = r_gnt;
    assign q    = r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_q     <= 1'b0;
`ifndef TOGGLE_ARB_FIXED_PRIO_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_q <= r_q ^ t_en;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        // len is latched here; later changes are ignored.
                        r_sel   <= w_idx;
                        r_gnt   <= w_oh;
                        r_cnt   <= w_len;
                        r_state <= (w_len != '0) ? BURST : DONE;
                    end
                end
                BURST: begin
                    r_cnt <= r_cnt - 1'b1;
                    // A dropped request aborts; the toggle on this edge still lands.
                    if (!req[r_sel] || (r_cnt == LENW'(1))) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
`ifndef TOGGLE_ARB_FIXED_PRIO_EN
                    r_ptr   <= w_ptr_next;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef TOGGLE_ARB_FIXED_PRIO_EN
    // Pointer successor is only consumed by the round-robin build.
    logic w_unused;
    assign w_unused = ^w_ptr_next;
`endif

endmodule
`default_nettype wire

// File: tb/tb_toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_arbiter
// Purpose  : Scoreboard bench for toggle_arbiter. Stimulus pushes the
//            expected grant, final q and toggle count of each grant; a
//            monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_arbiter;

    localparam int NREQ = 4;
    localparam int LENW = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*LENW-1:0] len = '0;
    logic [NREQ-1:0]      gnt;
    logic                 t_en;
    logic                 q;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    toggle_arbiter #(
        .NREQ (NREQ),
        .LENW (LENW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .t_en  (t_en),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [3:0] gnt;
        logic       q;
        int         tog;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   tcount      = 0;
    logic q_model     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Queue the expected result of one grant to requester r with tog toggles.
    task automatic expect_grant(input int r, input int tog);
        exp_t e;
        e.gnt   = 4'(1 << r);
        q_model = q_model ^ tog[0];
        e.q     = q_model;
        e.tog   = tog;
        sb.push_back(e);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 100);
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done after %0d cycles, expected one", cycles);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        q_model = 1'b0;
    endtask

    // Monitor: counts toggle cycles and scores each done pulse.
    always @(negedge clk) begin
        if (reset) begin
            tcount = 0;
        end else begin
            if (t_en) tcount++;
            if (done) begin
                check("done_excl_t_en", 32'(t_en), 0);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: gnt=%b, expected no done", gnt);
                end else begin
                    m_e = sb.pop_front();
                    check("grant", 32'(gnt), 32'(m_e.gnt));
                    check("q_end", 32'(q), 32'(m_e.q));
                    check("toggles", tcount, m_e.tog);
                end
                tcount = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        cyc = 0;
        do_reset();
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_q", 32'(q), 0);
        check("rst_t_en", 32'(t_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        // Single request, burst of 3.
        len[3:0] = 4'd3;
        expect_grant(0, 3);
        req = 4'b0001;
        @(negedge clk);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_busy", 32'(busy), 1);
        wait_done(cyc);
        req = '0;
        @(negedge clk);
        check("t1_gnt_clear", 32'(gnt), 0);
        check("t1_busy_clear", 32'(busy), 0);

        // Round-robin over all four, length 1 each: order 0,1,2,3,0.
        do_reset();
        len = 16'h1111;
        expect_grant(0, 1);
        expect_grant(1, 1);
        expect_grant(2, 1);
        expect_grant(3, 1);
        expect_grant(0, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(cyc);
            if (k > 0) check("t2_period", cyc, 3);
        end
        req = '0;
        @(negedge clk);

        // Zero-length burst: straight to DONE, q unchanged.
        len[11:8] = 4'd0;
        expect_grant(2, 0);
        req = 4'b0100;
        wait_done(cyc);
        check("t3_len0_latency", cyc, 1);
        req = '0;
        @(negedge clk);

        // Abort after two burst cycles out of seven.
        do_reset();
        len[7:4] = 4'd7;
        expect_grant(1, 2);
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        req = '0;
        wait_done(cyc);
        check("t4_abort_done_next", cyc, 1);
        @(negedge clk);

        // Reset in the middle of a burst of 5.
        len[7:4] = 4'd5;
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        req = '0;
        #1;
        check("t5_rst_gnt", 32'(gnt), 0);
        check("t5_rst_q", 32'(q), 0);
        check("t5_rst_t_en", 32'(t_en), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        q_model = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        len[7:4] = 4'd2;
        expect_grant(1, 2);
        req = 4'b0010;
        @(negedge clk);
        check("t5_regrant", 32'(gnt), 32'h2);
        wait_done(cyc);
        req = '0;
        @(negedge clk);

        // Two requesters held across two grants.
        do_reset();
        len = 16'h1111;
        expect_grant(1, 1);
`ifdef TOGGLE_ARB_FIXED_PRIO_EN
        expect_grant(1, 1);
`else
        expect_grant(3, 1);
`endif
        req = 4'b1010;
        wait_done(cyc);
        wait_done(cyc);
        req = '0;
        @(negedge clk);
        @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/toggle_arbiter.md
Name: toggle_arbiter

Overview:
- Shares one T-flip-flop toggle resource between NREQ requesters; each requester asks for a burst of N consecutive toggles.
- Round-robin arbitration grants one requester at a time.
- While a requester holds the grant, the block drives the toggle enable for exactly N cycles, then pulses done.
- Holds the shared toggle state q internally; sits between requester logic and whatever consumes q.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LENW, 4, width of each burst-length field; max burst 2^LENW-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held high until its done.
- len  in  NREQ*LENW  burst length; requester i uses bits [i*LENW +: LENW]; sampled at grant.
- gnt  out  NREQ  one-hot grant, registered.
- t_en  out  1  toggle enable to the shared flip-flop; high in BURST.
- q  out  1  shared toggle state; q <= q ^ t_en each clk.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at end of each grant.

Behaviour:
- Reset (async, active-high):
  - Outputs: gnt=0, q=0, t_en=0, busy=0, done=0.
  - Internal: state=IDLE, rr_ptr=0, cnt=0.
- States: IDLE, BURST, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from rr_ptr and wrapping.
  - On that edge: gnt = onehot(sel); cnt = len[sel]; next state = BURST if len[sel] != 0, else DONE.
  - If no req bit is set, remain in IDLE with gnt=0.
- BURST:
  - t_en=1 combinationally; q toggles on every edge.
  - cnt decrements each edge; at cnt==1 the next state is DONE.
  - Exactly len[sel] toggles occur; q ends at q_start ^ len[sel][0].
- DONE:
  - done=1 and t_en=0 for one cycle; gnt still held.
  - Next edge: gnt=0, rr_ptr=(sel+1) mod NREQ, state=IDLE.
- Throughput:
  - Arbitration happens in IDLE, so consecutive grants are separated by one IDLE cycle.
  - Full cycle for burst L: 1 (IDLE) + L (BURST) + 1 (DONE).
- Abort:
  - If req[sel] drops during BURST, the next edge goes to DONE.
  - Remaining toggles are skipped; done still pulses.
  - Toggles already applied to q are not undone.
- len changes after the grant edge are ignored; the value is latched.
- req from other requesters during a burst are not acted on; they are arbitrated at the next IDLE.
- Reset mid-burst aborts immediately to the reset values above; no done pulse.
- gnt is always one-hot or zero; done never coincides with t_en.

Optional Feature:
- Macro: TOGGLE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed and held at 0.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package toggle_arb_pkg holds:
  - state enum (IDLE, BURST, DONE);
  - default NREQ/LENW constants;
  - a function computing a one-hot from an index.
- Sub-module toggle_arb_rr_pick: combinational pick of the first set bit at or after the pointer, with wrap. It outputs index and valid and is reused for the fixed-priority build with the pointer tied to 0.

Test Plan:
- Reset then single request: req=4'b0001, len0=3 → gnt=0001 one cycle after; t_en high 3 cycles; q ends 1; done pulses once; then gnt=0.
- Round-robin fairness: req=4'b1111, all len=1 → grant order 0,1,2,3,0; each grant lasts 3 cycles with a 1-cycle IDLE gap.
- Zero-length burst: req=4'b0100, len2=0 → gnt=0100 then DONE; done=1, no t_en, q unchanged.
- Abort: len1=7, drop req1 after 2 BURST cycles → exactly 2 toggles, done pulses next cycle, q=0 from q=0 start.
- Mid-burst reset: assert reset during a burst of len=5 → gnt, q, t_en, busy, done all 0 asynchronously; after release, req=0010 is granted first (rr_ptr=0).
- TOGGLE_ARB_FIXED_PRIO_EN defined: req=4'b1010 held across two grants → requester 1 granted both times, 3 never.
